led_uart_tx: RTL

Buffered serial reporter downstream of the MiniAlu LED output register. Each time the program executes an LED instruction, the 8-bit value and a one-cycle strobe are pushed into this block. It queues the value in a small FIFO and shifts it out as 8N1 asynchronous serial on a single pin. This lets a host terminal log program results without sampling the LEDs.

---
 rtl/led_uart_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/led_uart_tx.sv
// led_uart_tx: buffered 8N1 serial reporter for LED register writes.
// Each accepted byte is queued in a small circular FIFO and shifted out LSB first
// with one start bit and one stop bit. Back-to-back frames are sent with no idle gap.
//
// Ports:
//   Clock     - single rising-edge clock
//   Reset     - synchronous, active-low
//   iData     - byte to queue
//   iValid    - push request, accepted when oReady is high
//   oReady    - FIFO not full (from registered occupancy)
//   oTx       - registered serial line, idles high
//   oBusy     - FIFO non-empty or frame in progress
//   oOverflow - sticky flag, set by a push attempted while oReady is low
//   oCount    - FIFO occupancy, 0..2**FIFO_AW
module led_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_AW      = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [7:0]       iData,
   input  logic             iValid,
   output logic             oReady,
   output logic             oTx,
   output logic             oBusy,
   output logic             oOverflow,
   output logic [FIFO_AW:0] oCount
);

   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam int unsigned CntW  = FIFO_AW + 1;
   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BaudW-1:0]   BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BaudW-1:0]   BaudOne  = BaudW'(1);
   localparam logic [CntW-1:0]    CntFull  = CntW'(Depth);
   localparam logic [CntW-1:0]    CntOne   = CntW'(1);
   localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StStart = 2'd1;
   localparam logic [1:0] StData  = 2'd2;
   localparam logic [1:0] StStop  = 2'd3;

   logic [7:0]         fifoMem [Depth];
   logic [FIFO_AW-1:0] wrPtrQ, wrPtrD;
   logic [FIFO_AW-1:0] rdPtrQ, rdPtrD;
   logic [CntW-1:0]    countQ, countD;
   logic [1:0]         stateQ, stateD;
   logic [BaudW-1:0]   baudQ, baudD;
   logic [2:0]         bitIdxQ, bitIdxD;
   logic [7:0]         shiftQ, shiftD;
   logic               txQ, txD;
   logic               overflowQ, overflowD;

   logic push;
   logic pop;
   logic fifoEmpty;
   logic baudDone;

   // Ready is derived from the registered count only, so a full FIFO refuses a push
   // even when a pop happens on the same edge.
   assign oReady    = (countQ != CntFull);
   assign push      = iValid & oReady;
   assign fifoEmpty = (countQ == '0);
   assign baudDone  = (baudQ == BaudLast);

   always_comb begin
      stateD    = stateQ;
      baudD     = baudQ;
      bitIdxD   = bitIdxQ;
      shiftD    = shiftQ;
      txD       = txQ;
      pop       = 1'b0;
      overflowD = overflowQ | (iValid & ~oReady);

      case (stateQ)
         StIdle: begin
            baudD = '0;
            txD   = 1'b1;
            if (!fifoEmpty) begin
               pop    = 1'b1;
               shiftD = fifoMem[rdPtrQ];
               stateD = StStart;
               txD    = 1'b0;
            end
         end
         StStart: begin
            if (baudDone) begin
               baudD   = '0;
               bitIdxD = 3'd0;
               stateD  = StData;
               txD     = shiftQ[0];
            end else begin
               baudD = baudQ + BaudOne;
            end
         end
         StData: begin
            if (baudDone) begin
               baudD = '0;
               if (bitIdxQ == 3'd7) begin
                  stateD = StStop;
                  txD    = 1'b1;
               end else begin
                  bitIdxD = bitIdxQ + 3'd1;
                  txD     = shiftQ[bitIdxD];
               end
            end else begin
               baudD = baudQ + BaudOne;
            end
         end
         StStop: begin
            if (baudDone) begin
               baudD = '0;
               // Chain straight into the next start bit when more data is waiting.
               if (!fifoEmpty) begin
                  pop    = 1'b1;
                  shiftD = fifoMem[rdPtrQ];
                  stateD = StStart;
                  txD    = 1'b0;
               end else begin
                  stateD = StIdle;
                  txD    = 1'b1;
               end
            end else begin
               baudD = baudQ + BaudOne;
            end
         end
         default: begin
            stateD = StIdle;
            baudD  = '0;
            txD    = 1'b1;
         end
      endcase

      wrPtrD = push ? (wrPtrQ + PtrOne) : wrPtrQ;
      rdPtrD = pop ? (rdPtrQ + PtrOne) : rdPtrQ;

      case ({push, pop})
         2'b10:   countD = countQ + CntOne;
         2'b01:   countD = countQ - CntOne;
         default: countD = countQ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         stateQ    <= StIdle;
         baudQ     <= '0;
         bitIdxQ   <= 3'd0;
         shiftQ    <= 8'h00;
         txQ       <= 1'b1;
         wrPtrQ    <= '0;
         rdPtrQ    <= '0;
         countQ    <= '0;
         overflowQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         baudQ     <= baudD;
         bitIdxQ   <= bitIdxD;
         shiftQ    <= shiftD;
         txQ       <= txD;
         wrPtrQ    <= wrPtrD;
         rdPtrQ    <= rdPtrD;
         countQ    <= countD;
         overflowQ <= overflowD;
      end
   end

   // Storage needs no reset; occupancy alone decides which entries are valid.
   always_ff @(posedge Clock) begin
      if (Reset && push) begin
         fifoMem[wrPtrQ] <= iData;
      end
   end

   assign oTx       = txQ;
   assign oBusy     = (stateQ != StIdle) | (countQ != '0);
   assign oOverflow = overflowQ;
   assign oCount    = countQ;

endmodule
